alsu_param: RTL
===============

Name: alsu_param

Overview:
Parametrised, two-stage pipelined arithmetic/logic/shift unit, successor to the fixed 3-bit ALSU. Operand width and output width are generic. A valid handshake marks which operations take effect. Invalid operations drive a sticky error flag and a clocked LED blink state machine. It sits in the datapath behind the operand/opcode sources and drives the result bus and the 16 board LEDs.

Parameters:
WIDTH, 3, operand width of A and B (>=2)
OUT_W, 2*WIDTH, result width (fixed at 2*WIDTH, not overridable)
INPUT_PRIORITY, "A", operand chosen when both red_op or both bypass are set ("A" or "B")
FULL_ADDER, 1, 1 = add includes cin, 0 = cin ignored
BLINK_DIV, 4, clock cycles between LED toggles in ERROR state (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
A  in  WIDTH  operand A
B  in  WIDTH  operand B
opcode  in  3  operation select
cin  in  1  carry in
serial_in  in  1  shift fill bit
direction  in  1  1 = left, 0 = right
red_op_A  in  1  reduce A (opcodes 0/1 only)
red_op_B  in  1  reduce B (opcodes 0/1 only)
bypass_A  in  1  pass A to out
bypass_B  in  1  pass B to out
in_valid  in  1  operation request this cycle
err_clr  in  1  clears err_sticky
out  out  OUT_W  registered result
out_valid  out  1  out updated this cycle
leds  out  16  error indicator
err_sticky  out  1  latched invalid-operation flag

Behaviour:
- Reset (asynchronous, active-high, any time, including mid-pipeline): all stage-1 registers, out, out_valid, leds, err_sticky, blink counter and FSM go to 0 / NORMAL. Any in-flight operation is discarded.
- Stage 1: every clock, registers all inputs and in_valid into v1.
- Stage 2: if v1=1, updates out and sets out_valid=1. If v1=0, out holds its value and out_valid=0.
- Latency: 2 clocks from the sampling edge to out. Throughput: 1 operation per clock.
- Priority, highest first:
  - Bypass: bypass_A only -> A; bypass_B only -> B; both -> the INPUT_PRIORITY operand. Result is zero-extended.
  - Invalid: opcode 6 or 7, or (red_op_A|red_op_B) with opcode not in {0,1}. Result: out<=0.
  - Opcode decode, all results zero-extended to OUT_W:
    - 0 AND: A&B, or &A / &B when red_op set (both set -> INPUT_PRIORITY operand).
    - 1 XOR: A^B, or ^A / ^B by the same red_op rule.
    - 2 ADD: A+B+(FULL_ADDER?cin:0). Carry is kept; no overflow is possible within OUT_W.
    - 3 MULT: A*B, full product.
    - 4 SHIFT: operates on current out. Left -> {out[OUT_W-2:0],serial_in}; right -> {serial_in,out[OUT_W-1:1]}.
    - 5 ROTATE: operates on current out. Left -> {out[OUT_W-2:0],out[OUT_W-1]}; right -> {out[0],out[OUT_W-1:1]}.
  - Back-to-back shift/rotate: each uses the out value produced the previous cycle, so the chain is cumulative.
- LED FSM, states NORMAL and ERROR:
  - NORMAL: leds=0.
  - NORMAL->ERROR: on a stage-2 invalid op. leds<=16'hFFFF, blink counter<=0.
  - In ERROR, each clock the counter increments. When it reaches BLINK_DIV-1: leds<=~leds, counter<=0.
  - ERROR->NORMAL: on a stage-2 valid, non-invalid op (bypass counts). leds<=0.
  - Another invalid op while in ERROR: stays in ERROR, does not restart the blink phase.
  - v1=0 cycles: no state change; blinking continues.
- err_sticky:
  - Set on any stage-2 invalid op.
  - Cleared by err_clr when no invalid op completes that cycle.
  - Set wins if both happen in the same cycle.

Test Plan:
- Reset + bypass: rst=1 for 2 clocks -> out=0, leds=0, err_sticky=0. Then rst=0, bypass_A=1, A=5, in_valid=1 -> 2 clocks later out=6'b000101, out_valid=1. Both bypasses with A=5, B=2 -> out=5.
- Arithmetic: A=7, B=7, cin=1, op 2 -> out=15. Same with FULL_ADDER=0 -> out=14. A=7, B=6, op 3 -> out=42. Back-to-back over 3 cycles -> results emerge on 3 consecutive cycles.
- Reduction: A=3'b111, B=3'b010, red_op_A=1, op 0 -> out=1. red_op_B=1 only, op 1 -> out=1. Both red_op set, op 0 -> out=1 (&A).
- Shift/rotate chain: out=6'b000001, then op 4, direction=1, serial_in=1 -> 000011. Then op 5, direction=0 -> 100001. Then op 5, direction=0 -> 110000.
- Invalid/LED: op 6 valid -> out=0, leds=FFFF, err_sticky=1. With BLINK_DIV=4, leds toggle to 0000 4 clocks after entering ERROR, then back to FFFF 4 clocks later. A valid op 2 -> leds=0, err_sticky stays 1. err_clr=1 -> 0.
- Valid gating / reset mid-op: in_valid=0 with op 2 -> out holds, out_valid=0. Assert rst between stage 1 and stage 2 of an op -> out stays 0 and out_valid=0 after release.

Source files
------------

// File: rtl/alsu_param_if.sv
// alsu_param_if: operand/opcode request bus and result/LED status bus of the ALSU
interface alsu_param_if #(parameter int WIDTH = 3);
  localparam int OUT_W = 2 * WIDTH;
  logic [WIDTH-1:0] A, B;
  logic [2:0] opcode;
  logic cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B, in_valid, err_clr;
  logic [OUT_W-1:0] out;
  logic out_valid;
  logic [15:0] leds;
  logic err_sticky;
  modport master (
    output A, B, opcode, cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B, in_valid, err_clr,
    input out, out_valid, leds, err_sticky
  );
  modport slave (
    input A, B, opcode, cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B, in_valid, err_clr,
    output out, out_valid, leds, err_sticky
  );
endinterface

// File: rtl/alsu_param.sv
// alsu_param: two-stage pipelined arithmetic/logic/shift unit with sticky error flag and LED blink FSM
module alsu_param #(
  parameter int WIDTH = 3,
  parameter INPUT_PRIORITY = "A",
  parameter bit FULL_ADDER = 1'b1,
  parameter int BLINK_DIV = 4
) (
  input logic clk,
  input logic rst,
  alsu_param_if.slave bus
);
  localparam int OUT_W = 2 * WIDTH;
  localparam int CW = $clog2(BLINK_DIV + 1);
  localparam bit PRI_A = (INPUT_PRIORITY == "A");
  typedef enum logic {NORMAL, ERROR} state_t;
  logic [WIDTH-1:0] a1, b1, byp, red;
  logic [2:0] op1;
  logic cin1, sin1, dir1, ra1, rb1, ba1, bb1, v1, inv;
  logic [OUT_W-1:0] out_r, op_res, res;
  logic ov_r, err_r;
  logic [15:0] leds_r;
  logic [CW-1:0] cnt;
  state_t state;
  assign bus.out = out_r;
  assign bus.out_valid = ov_r;
  assign bus.leds = leds_r;
  assign bus.err_sticky = err_r;
  always_ff @(posedge clk or posedge rst)
    if (rst) {a1, b1, op1, cin1, sin1, dir1, ra1, rb1, ba1, bb1, v1} <= '0;
    else {a1, b1, op1, cin1, sin1, dir1, ra1, rb1, ba1, bb1, v1} <= {bus.A, bus.B, bus.opcode, bus.cin,
      bus.serial_in, bus.direction, bus.red_op_A, bus.red_op_B, bus.bypass_A, bus.bypass_B, bus.in_valid};
  always_comb begin
    byp = (ba1 && bb1) ? (PRI_A ? a1 : b1) : ba1 ? a1 : b1;
    red = (ra1 && rb1) ? (PRI_A ? a1 : b1) : ra1 ? a1 : b1;
    inv = !(ba1 || bb1) && ((op1[2] && op1[1]) || ((ra1 || rb1) && op1[2:1] != 2'b00));
    case (op1)
      3'd0: op_res = (ra1 || rb1) ? OUT_W'(&red) : OUT_W'(a1 & b1);
      3'd1: op_res = (ra1 || rb1) ? OUT_W'(^red) : OUT_W'(a1 ^ b1);
      3'd2: op_res = OUT_W'(a1) + OUT_W'(b1) + OUT_W'(FULL_ADDER & cin1);
      3'd3: op_res = OUT_W'(a1) * OUT_W'(b1);
      3'd4: op_res = dir1 ? {out_r[OUT_W-2:0], sin1} : {sin1, out_r[OUT_W-1:1]};
      3'd5: op_res = dir1 ? {out_r[OUT_W-2:0], out_r[OUT_W-1]} : {out_r[0], out_r[OUT_W-1:1]};
      default: op_res = '0;
    endcase
    res = (ba1 || bb1) ? OUT_W'(byp) : inv ? '0 : op_res;
  end
  // Blink phase is only restarted on entry from NORMAL, never by repeated invalid ops.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_r <= '0;
      ov_r <= 1'b0;
      err_r <= 1'b0;
      leds_r <= '0;
      cnt <= '0;
      state <= NORMAL;
    end else begin
      ov_r <= v1;
      if (v1) out_r <= res;
      err_r <= (v1 && inv) || (err_r && !bus.err_clr);
      if (state == NORMAL) begin
        if (v1 && inv) begin
          state <= ERROR;
          leds_r <= '1;
          cnt <= '0;
        end
      end else if (v1 && !inv) begin
        state <= NORMAL;
        leds_r <= '0;
        cnt <= '0;
      end else if (cnt == CW'(BLINK_DIV - 1)) begin
        leds_r <= ~leds_r;
        cnt <= '0;
      end else cnt <= cnt + CW'(1);
    end
endmodule
